pipe_lane_ctrl: RTL and testbench
=================================

Name: pipe_lane_ctrl

Overview:
Multi-lane successor to the single-lane PIPE control block. It sits between the LTSSM (substate/generation/requests) and a NUM_LANES-wide PIPE PHY interface.
- Sequences PowerDown and Rate changes with a per-lane PhyStatus completion handshake.
- Runs receiver detection with a per-lane result vector.
- Drives TxElecIdle per lane, honouring a lane-enable mask.
- Flags PHY handshakes that never complete via a timeout.

Parameters:
NUM_LANES, 4, number of PIPE lanes (1..16)
TIMEOUT_CYCLES, 1024, pclk cycles to wait for all-lane PhyStatus before aborting
MAX_RATE, 4, highest legal Rate encoding (Gen5 = 4)

Ports:
pclk  in  1  PIPE clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
substate  in  4  LTSSM substate (0 DetectQuiet, 1 DetectActive, >1 active states)
generation  in  3  negotiated generation (1..5)
ElecIdle_req  in  1  force electrical idle on all lanes
Detect_req  in  1  request receiver detection (level)
lane_en  in  NUM_LANES  per-lane enable; disabled lanes are idle and ignored in handshakes
PhyStatus  in  NUM_LANES  per-lane PHY completion pulse
RxStatus  in  3*NUM_LANES  per-lane RxStatus, lane i at [3i+2:3i]
TxDetectRx_Loopback  out  1  receiver-detect request to PHY
PowerDown  out  4  PIPE power state (0 = P0, 2 = P1)
Rate  out  3  PIPE rate encoding
TxElecIdle  out  NUM_LANES  per-lane electrical idle
Lanes_detected  out  NUM_LANES  per-lane receiver-present result
Detect_done  out  1  detection complete, results valid
Detect_status  out  1  Detect_done AND any lane detected
busy  out  1  handshake in progress (state != IDLE)
timeout_err  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset (async, any time, including mid-handshake):
  - PowerDown = 2, Rate = 0, TxElecIdle = all 1, TxDetectRx_Loopback = 0.
  - Lanes_detected = 0, Detect_done = 0, Detect_status = 0, busy = 0, timeout_err = 0.
  - state = IDLE, seen mask = 0, timer = 0.
- Derived targets:
  - tgt_pd = 2 when substate <= 1, else 0.
  - tgt_rate = min(generation-1, MAX_RATE); generation = 0 maps to 0.
- Seen mask: seen[i] is set on PhyStatus[i]=1 and is sticky. Disabled lanes (~lane_en[i]) count as seen. all_seen = &seen.
- FSM states: IDLE, PD_WAIT, RATE_WAIT, DET_WAIT.
- IDLE, evaluated each cycle in priority order:
  - (1) tgt_pd != PowerDown: register PowerDown = tgt_pd, clear seen, clear timer -> PD_WAIT.
  - (2) else PowerDown == 0 and tgt_rate != Rate: register Rate = tgt_rate, clear seen and timer -> RATE_WAIT.
  - (3) else PowerDown == 2, Detect_req = 1, Detect_done = 0: TxDetectRx_Loopback = 1, clear seen, Lanes_detected and timer -> DET_WAIT.
  - PhyStatus pulses arriving in IDLE are ignored.
- PD_WAIT / RATE_WAIT:
  - Timer increments each cycle.
  - all_seen -> IDLE on the next edge.
  - Timer reaches TIMEOUT_CYCLES-1 without all_seen -> timeout_err pulse, -> IDLE. The new PowerDown/Rate value is kept.
- DET_WAIT:
  - On PhyStatus[i] for an enabled lane with RxStatus lane == 3'b011, set Lanes_detected[i].
  - all_seen -> TxDetectRx_Loopback = 0, Detect_done = 1, -> IDLE.
  - Timeout -> TxDetectRx_Loopback = 0, Detect_done = 1 with partial results, timeout_err pulse.
  - Simultaneous PhyStatus on the last lanes in the same cycle completes in that cycle.
- Detect_done stays set until Detect_req = 0. It clears on the first cycle Detect_req is low, together with Detect_status; Lanes_detected is held. Re-detection needs Detect_req to go low, then high.
- Detect_status = Detect_done & |Lanes_detected (registered).
- Target changes while busy are not acted on; they are picked up on return to IDLE.
- TxElecIdle[i] is registered: 1 if ElecIdle_req | substate <= 1 | ~lane_en[i] | state == PD_WAIT, else 0. Latency is one pclk.
- Timer width = $clog2(TIMEOUT_CYCLES)+1. The timer saturates and never wraps.

Decomposition:
- Shared package pipe_pkg holds:
  - LTSSM substate localparams (DetectQuiet..Idle).
  - PD_P0 = 0, PD_P1 = 2.
  - RXSTAT_DETECTED = 3'b011.
  - FSM state encoding.
- One sub-module, pipe_phystatus_collector: per-lane sticky seen mask, lane_en masking, all_seen, timer and timeout flag. Ports: clear and start. It is reused by all three wait states.

Test Plan:
- Reset, then substate = 2 -> PowerDown 2 -> 0 next edge, busy = 1; PhyStatus = 4'b1111 -> busy = 0 next edge; TxElecIdle = 4'b0000.
- substate = 1, Detect_req = 1, PhyStatus lanes 0..3 on separate cycles, RxStatus lanes 0 and 2 = 3'b011 -> TxDetectRx 1 until the last pulse; Lanes_detected = 4'b0101, Detect_done = 1, Detect_status = 1; Detect_req = 0 -> both clear.
- lane_en = 4'b0011 in P0 with generation 1 -> 5 -> Rate = 4; PhyStatus only on lanes 0-1 completes; TxElecIdle = 4'b1100.
- Rate change with PhyStatus only on lane 0 -> timeout_err pulse exactly TIMEOUT_CYCLES cycles after entry; Rate stays 4; busy drops.
- Detection with no receivers (RxStatus 3'b000) -> Detect_done = 1, Detect_status = 0, Lanes_detected = 0.
- reset_n low during DET_WAIT -> TxDetectRx = 0, PowerDown = 2, Lanes_detected = 0 immediately (asynchronous).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the multi-lane PIPE control block: LTSSM substates,
// PIPE power/status encodings, controller state encoding and the rate target rule.
package pipe_pkg;

  localparam logic [3:0] SS_DETECT_QUIET  = 4'd0;
  localparam logic [3:0] SS_DETECT_ACTIVE = 4'd1;
  localparam logic [3:0] SS_POLLING       = 4'd2;
  localparam logic [3:0] SS_CONFIG        = 4'd3;
  localparam logic [3:0] SS_L0            = 4'd4;
  localparam logic [3:0] SS_RECOVERY      = 4'd5;
  localparam logic [3:0] SS_IDLE          = 4'd6;

  localparam logic [3:0] PD_P0 = 4'd0;
  localparam logic [3:0] PD_P1 = 4'd2;

  localparam logic [2:0] RXSTAT_DETECTED = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PD_WAIT   = 2'd1,
    ST_RATE_WAIT = 2'd2,
    ST_DET_WAIT  = 2'd3
  } lane_state_e;

  // Generation 1..5 maps to Rate 0..4; generation 0 is treated as Gen1.
  function automatic logic [2:0] calc_tgt_rate(input logic [2:0] gen, input logic [2:0] max_rate);
    logic [2:0] rate;
    if (gen == 3'd0) begin
      rate = 3'd0;
    end else if ((gen - 3'd1) > max_rate) begin
      rate = max_rate;
    end else begin
      rate = gen - 3'd1;
    end
    return rate;
  endfunction

endpackage

// File: rtl/pipe_phystatus_collector.sv
// Collects per-lane PhyStatus completions for one handshake and times out
// handshakes that never finish on every enabled lane.
module pipe_phystatus_collector
  import pipe_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 start,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic [NUM_LANES-1:0] phystatus,
  output logic                 all_seen,
  output logic                 timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};

  logic [NUM_LANES-1:0] r_seen;
  logic [TW-1:0]        r_timer;
  logic [NUM_LANES-1:0] w_seen_now;

  // Sticky seen mask and saturating handshake timer.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_seen  <= {NUM_LANES{1'b0}};
      r_timer <= {TW{1'b0}};
    end else if (clear) begin
      r_seen  <= {NUM_LANES{1'b0}};
      r_timer <= {TW{1'b0}};
    end else if (start) begin
      r_seen <= r_seen | phystatus;
      if (r_timer != TMR_MAX) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= r_timer;
      end
    end else begin
      r_seen  <= r_seen;
      r_timer <= r_timer;
    end
  end

  // Pulses arriving this cycle count, so the last lanes complete without an extra cycle.
  always_comb begin
    w_seen_now = r_seen | phystatus | ~lane_en;
    all_seen   = start & (&w_seen_now);
    timeout    = start & ~all_seen & (r_timer >= TMR_LAST);
  end

endmodule

// File: rtl/pipe_lane_ctrl.sv
// Multi-lane PIPE control: sequences PowerDown/Rate changes and receiver
// detection against per-lane PhyStatus, and drives per-lane TxElecIdle.
module pipe_lane_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RATE       = 4
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic [3:0]             substate,
  input  logic [2:0]             generation,
  input  logic                   ElecIdle_req,
  input  logic                   Detect_req,
  input  logic [NUM_LANES-1:0]   lane_en,
  input  logic [NUM_LANES-1:0]   PhyStatus,
  input  logic [3*NUM_LANES-1:0] RxStatus,
  output logic                   TxDetectRx_Loopback,
  output logic [3:0]             PowerDown,
  output logic [2:0]             Rate,
  output logic [NUM_LANES-1:0]   TxElecIdle,
  output logic [NUM_LANES-1:0]   Lanes_detected,
  output logic                   Detect_done,
  output logic                   Detect_status,
  output logic                   busy,
  output logic                   timeout_err
);

  lane_state_e          r_state;
  logic [3:0]           r_pd;
  logic [2:0]           r_rate;
  logic                 r_txdet;
  logic [NUM_LANES-1:0] r_lanes;
  logic                 r_done;
  logic                 r_status;
  logic                 r_busy;
  logic                 r_tmo;
  logic [NUM_LANES-1:0] r_elec;

  lane_state_e          w_state_nxt;
  logic [3:0]           w_pd_nxt;
  logic [2:0]           w_rate_nxt;
  logic                 w_txdet_nxt;
  logic [NUM_LANES-1:0] w_lanes_nxt;
  logic                 w_done_nxt;
  logic                 w_status_nxt;
  logic                 w_busy_nxt;
  logic                 w_tmo_nxt;
  logic [NUM_LANES-1:0] w_elec_nxt;

  logic [3:0]           w_tgt_pd;
  logic [2:0]           w_tgt_rate;
  logic [NUM_LANES-1:0] w_rx_hit;
  logic                 w_clear;
  logic                 w_in_wait;
  logic                 w_all_seen;
  logic                 w_timeout;

  assign w_in_wait = (r_state != ST_IDLE);

  pipe_phystatus_collector #(
    .NUM_LANES      (NUM_LANES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_collector (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .clear     (w_clear),
    .start     (w_in_wait),
    .lane_en   (lane_en),
    .phystatus (PhyStatus),
    .all_seen  (w_all_seen),
    .timeout   (w_timeout)
  );

  // Targets requested by the LTSSM and the per-lane receiver-present hits.
  always_comb begin
    w_tgt_pd   = (substate <= SS_DETECT_ACTIVE) ? PD_P1 : PD_P0;
    w_tgt_rate = calc_tgt_rate(generation, 3'(MAX_RATE));
    w_rx_hit   = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      w_rx_hit[i] = PhyStatus[i] & lane_en[i] & (RxStatus[3*i +: 3] == RXSTAT_DETECTED);
    end
  end

  // Next-state and next-output logic for the handshake sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_pd_nxt    = r_pd;
    w_rate_nxt  = r_rate;
    w_txdet_nxt = r_txdet;
    w_lanes_nxt = r_lanes;
    w_tmo_nxt   = 1'b0;
    w_clear     = 1'b0;
    if (r_done && !Detect_req) begin
      w_done_nxt = 1'b0;
    end else begin
      w_done_nxt = r_done;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_tgt_pd != r_pd) begin
          w_pd_nxt    = w_tgt_pd;
          w_clear     = 1'b1;
          w_state_nxt = ST_PD_WAIT;
        end else if ((r_pd == PD_P0) && (w_tgt_rate != r_rate)) begin
          w_rate_nxt  = w_tgt_rate;
          w_clear     = 1'b1;
          w_state_nxt = ST_RATE_WAIT;
        end else if ((r_pd == PD_P1) && Detect_req && !r_done) begin
          w_txdet_nxt = 1'b1;
          w_lanes_nxt = {NUM_LANES{1'b0}};
          w_clear     = 1'b1;
          w_state_nxt = ST_DET_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PD_WAIT, ST_RATE_WAIT: begin
        if (w_all_seen) begin
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_tmo_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_DET_WAIT: begin
        w_lanes_nxt = r_lanes | w_rx_hit;
        if (w_all_seen) begin
          w_txdet_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_txdet_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DET_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_status_nxt = w_done_nxt & (|w_lanes_nxt);
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_elec_nxt   = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      w_elec_nxt[i] = ElecIdle_req | (substate <= SS_DETECT_ACTIVE) | ~lane_en[i] |
                      (r_state == ST_PD_WAIT);
    end
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_pd     <= PD_P1;
      r_rate   <= 3'd0;
      r_txdet  <= 1'b0;
      r_lanes  <= {NUM_LANES{1'b0}};
      r_done   <= 1'b0;
      r_status <= 1'b0;
      r_busy   <= 1'b0;
      r_tmo    <= 1'b0;
      r_elec   <= {NUM_LANES{1'b1}};
    end else begin
      r_state  <= w_state_nxt;
      r_pd     <= w_pd_nxt;
      r_rate   <= w_rate_nxt;
      r_txdet  <= w_txdet_nxt;
      r_lanes  <= w_lanes_nxt;
      r_done   <= w_done_nxt;
      r_status <= w_status_nxt;
      r_busy   <= w_busy_nxt;
      r_tmo    <= w_tmo_nxt;
      r_elec   <= w_elec_nxt;
    end
  end

  assign TxDetectRx_Loopback = r_txdet;
  assign PowerDown           = r_pd;
  assign Rate                = r_rate;
  assign TxElecIdle          = r_elec;
  assign Lanes_detected      = r_lanes;
  assign Detect_done         = r_done;
  assign Detect_status       = r_status;
  assign busy                = r_busy;
  assign timeout_err         = r_tmo;

endmodule

// File: tb/tb_pipe_lane_ctrl.sv
// Directed bench for pipe_lane_ctrl: a transaction-level model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_pipe_lane_ctrl;

  localparam int NL = 4;
  localparam int TO = 1024;
  localparam int MR = 4;

  logic            pclk;
  logic            reset_n;
  logic [3:0]      substate;
  logic [2:0]      generation;
  logic            ElecIdle_req;
  logic            Detect_req;
  logic [NL-1:0]   lane_en;
  logic [NL-1:0]   PhyStatus;
  logic [3*NL-1:0] RxStatus;
  logic            TxDetectRx_Loopback;
  logic [3:0]      PowerDown;
  logic [2:0]      Rate;
  logic [NL-1:0]   TxElecIdle;
  logic [NL-1:0]   Lanes_detected;
  logic            Detect_done;
  logic            Detect_status;
  logic            busy;
  logic            timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic check_en = 1'b0;
  int cnt;

  pipe_lane_ctrl #(.NUM_LANES(NL), .TIMEOUT_CYCLES(TO), .MAX_RATE(MR)) dut (
    .pclk                (pclk),
    .reset_n             (reset_n),
    .substate            (substate),
    .generation          (generation),
    .ElecIdle_req        (ElecIdle_req),
    .Detect_req          (Detect_req),
    .lane_en             (lane_en),
    .PhyStatus           (PhyStatus),
    .RxStatus            (RxStatus),
    .TxDetectRx_Loopback (TxDetectRx_Loopback),
    .PowerDown           (PowerDown),
    .Rate                (Rate),
    .TxElecIdle          (TxElecIdle),
    .Lanes_detected      (Lanes_detected),
    .Detect_done         (Detect_done),
    .Detect_status       (Detect_status),
    .busy                (busy),
    .timeout_err         (timeout_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // kind: 0 no handshake, 1 power change, 2 rate change, 3 receiver detection
  typedef struct {
    int            kind;
    logic [3:0]    pd;
    logic [2:0]    rate;
    logic          txdet;
    logic [NL-1:0] lanes;
    logic          done;
    logic          status;
    logic          busy;
    logic          tmo;
    logic [NL-1:0] elec;
    logic [NL-1:0] got;
    int            age;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.kind = 0; r.pd = 4'd2; r.rate = 3'd0; r.txdet = 1'b0; r.lanes = 4'd0;
    r.done = 1'b0; r.status = 1'b0; r.busy = 1'b0; r.tmo = 1'b0;
    r.elec = 4'hF; r.got = 4'd0; r.age = 0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c);
    model_t n;
    int g, tgt_rate;
    logic [3:0] tgt_pd;
    logic [NL-1:0] owed;
    n = c;
    n.tmo = 1'b0;
    for (int i = 0; i < NL; i++) begin
      n.elec[i] = ElecIdle_req || (substate < 4'd2) || !lane_en[i] || (c.kind == 1);
    end
    if (c.done && !Detect_req) n.done = 1'b0;
    tgt_pd = (substate < 4'd2) ? 4'd2 : 4'd0;
    g = int'(generation);
    tgt_rate = (g == 0) ? 0 : (((g - 1) > MR) ? MR : g - 1);
    if (c.kind == 0) begin
      if (tgt_pd != c.pd) begin
        n.pd = tgt_pd; n.kind = 1; n.got = 4'd0; n.age = 0;
      end else if (c.pd == 4'd0 && tgt_rate != int'(c.rate)) begin
        n.rate = 3'(tgt_rate); n.kind = 2; n.got = 4'd0; n.age = 0;
      end else if (c.pd == 4'd2 && Detect_req && !c.done) begin
        n.kind = 3; n.txdet = 1'b1; n.lanes = 4'd0; n.got = 4'd0; n.age = 0;
      end
    end else begin
      n.got = c.got | PhyStatus;
      n.age = c.age + 1;
      if (c.kind == 3) begin
        for (int i = 0; i < NL; i++) begin
          if (PhyStatus[i] && lane_en[i] && RxStatus[3*i +: 3] == 3'b011) n.lanes[i] = 1'b1;
        end
      end
      owed = lane_en & ~n.got;
      if (owed == 4'd0 || n.age == TO) begin
        n.tmo = (owed != 4'd0);
        if (c.kind == 3) begin
          n.txdet = 1'b0; n.done = 1'b1;
        end
        n.kind = 0;
      end
    end
    n.busy = (n.kind != 0);
    n.status = n.done && (n.lanes != 4'd0);
    return n;
  endfunction

  always @(posedge pclk or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else          m <= model_step(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (check_en) begin
      check("m_PowerDown", 32'(PowerDown), 32'(m.pd));
      check("m_Rate", 32'(Rate), 32'(m.rate));
      check("m_TxDetectRx", 32'(TxDetectRx_Loopback), 32'(m.txdet));
      check("m_TxElecIdle", 32'(TxElecIdle), 32'(m.elec));
      check("m_Lanes_detected", 32'(Lanes_detected), 32'(m.lanes));
      check("m_Detect_done", 32'(Detect_done), 32'(m.done));
      check("m_Detect_status", 32'(Detect_status), 32'(m.status));
      check("m_busy", 32'(busy), 32'(m.busy));
      check("m_timeout_err", 32'(timeout_err), 32'(m.tmo));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; substate = 4'd0; generation = 3'd1; ElecIdle_req = 1'b0;
    Detect_req = 1'b0; lane_en = 4'b1111; PhyStatus = 4'd0; RxStatus = 12'd0;
    repeat (3) @(negedge pclk);
    reset_n = 1'b1;
    check_en = 1'b1;
    @(negedge pclk);
    check("rst_PowerDown", 32'(PowerDown), 32'd2);
    check("rst_Rate", 32'(Rate), 32'd0);
    check("rst_TxElecIdle", 32'(TxElecIdle), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_Detect_done", 32'(Detect_done), 32'd0);

    // P1 -> P0
    substate = 4'd2;
    @(negedge pclk);
    check("p0_PowerDown", 32'(PowerDown), 32'd0);
    check("p0_busy", 32'(busy), 32'd1);
    PhyStatus = 4'b1111;
    @(negedge pclk); PhyStatus = 4'd0;
    check("p0_busy_drop", 32'(busy), 32'd0);
    @(negedge pclk);
    check("p0_TxElecIdle", 32'(TxElecIdle), 32'h0);

    // back to P1, then detect with receivers on lanes 0 and 2
    substate = 4'd1; Detect_req = 1'b1; RxStatus = 12'b000_011_000_011;
    @(negedge pclk);
    check("p1_PowerDown", 32'(PowerDown), 32'd2);
    PhyStatus = 4'b1111;
    @(negedge pclk); PhyStatus = 4'd0;
    @(negedge pclk);
    check("det_txdet_start", 32'(TxDetectRx_Loopback), 32'd1);
    for (int i = 0; i < NL; i++) begin
      PhyStatus = 4'(1 << i);
      @(negedge pclk); PhyStatus = 4'd0;
      if (i < NL - 1) check("det_txdet_hold", 32'(TxDetectRx_Loopback), 32'd1);
    end
    check("det_lanes", 32'(Lanes_detected), 32'h5);
    check("det_done", 32'(Detect_done), 32'd1);
    check("det_status", 32'(Detect_status), 32'd1);
    check("det_txdet_end", 32'(TxDetectRx_Loopback), 32'd0);
    Detect_req = 1'b0;
    @(negedge pclk);
    check("det_done_clr", 32'(Detect_done), 32'd0);
    check("det_status_clr", 32'(Detect_status), 32'd0);
    check("det_lanes_held", 32'(Lanes_detected), 32'h5);

    // two lanes enabled, P0 then Gen5
    substate = 4'd2; generation = 3'd5; lane_en = 4'b0011;
    @(negedge pclk);
    check("ln_PowerDown", 32'(PowerDown), 32'd0);
    PhyStatus = 4'b0011;
    @(negedge pclk); PhyStatus = 4'd0;
    @(negedge pclk);
    check("ln_Rate", 32'(Rate), 32'd4);
    check("ln_busy", 32'(busy), 32'd1);
    PhyStatus = 4'b0011;
    @(negedge pclk); PhyStatus = 4'd0;
    check("ln_busy_drop", 32'(busy), 32'd0);
    @(negedge pclk);
    check("ln_TxElecIdle", 32'(TxElecIdle), 32'hC);

    // rate to Gen1, then clamped Gen6 request that times out
    lane_en = 4'b1111; generation = 3'd1;
    @(negedge pclk);
    check("rt_Rate0", 32'(Rate), 32'd0);
    PhyStatus = 4'b1111;
    @(negedge pclk); PhyStatus = 4'd0;
    generation = 3'd6;
    @(negedge pclk);
    check("rt_Rate_clamp", 32'(Rate), 32'd4);
    PhyStatus = 4'b0001;
    cnt = 0;
    while (!timeout_err && cnt < 2 * TO) begin
      @(negedge pclk); PhyStatus = 4'd0;
      cnt++;
    end
    check("tmo_latency", 32'(cnt), 32'(TO));
    check("tmo_Rate_kept", 32'(Rate), 32'd4);
    check("tmo_busy", 32'(busy), 32'd0);
    @(negedge pclk);
    check("tmo_pulse", 32'(timeout_err), 32'd0);

    // detection with no receivers, all lanes reporting together
    substate = 4'd1; Detect_req = 1'b1; RxStatus = 12'd0;
    @(negedge pclk);
    PhyStatus = 4'b1111;
    @(negedge pclk); PhyStatus = 4'd0;
    @(negedge pclk);
    check("nr_txdet", 32'(TxDetectRx_Loopback), 32'd1);
    PhyStatus = 4'b1111;
    @(negedge pclk); PhyStatus = 4'd0;
    check("nr_done", 32'(Detect_done), 32'd1);
    check("nr_status", 32'(Detect_status), 32'd0);
    check("nr_lanes", 32'(Lanes_detected), 32'd0);
    Detect_req = 1'b0;
    @(negedge pclk);

    // async reset in the middle of a detection
    Detect_req = 1'b1; RxStatus = 12'b000_000_011_000;
    @(negedge pclk);
    check("ar_txdet", 32'(TxDetectRx_Loopback), 32'd1);
    PhyStatus = 4'b0010;
    @(negedge pclk); PhyStatus = 4'd0;
    check("ar_lanes_partial", 32'(Lanes_detected), 32'h2);
    #2 reset_n = 1'b0;
    #1;
    check("ar_txdet_rst", 32'(TxDetectRx_Loopback), 32'd0);
    check("ar_PowerDown_rst", 32'(PowerDown), 32'd2);
    check("ar_lanes_rst", 32'(Lanes_detected), 32'd0);
    check("ar_busy_rst", 32'(busy), 32'd0);
    Detect_req = 1'b0;
    @(negedge pclk);
    reset_n = 1'b1;
    repeat (3) @(negedge pclk);
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
